dac_spi_tx: RTL and testbench

Output stage that sits directly downstream of the 25-bit high-pass filter (`pasaaltas_200`). It captures each filtered sample `y` on the filter's `rx_2` valid strobe, rounds and saturates it to a 12-bit offset-binary DAC code, and shifts it out in a 16-bit SPI-style frame to a serial DAC. A one-deep pending register absorbs samples that arrive while a frame is in flight; newer samples overwrite older ones.

---
 rtl/dac_spi_tx.sv | 118 +++++++++++
 tb/tb_dac_spi_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: rounds/saturates filter samples to offset-binary DAC codes and
// shifts them out as 16-bit SPI frames, with a one-deep overwrite-on-full pending slot.
module dac_spi_tx #(
    parameter int DATA_W  = 25,
    parameter int DAC_W   = 12,
    parameter int SHIFT   = 10,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_2,
    input  logic [DATA_W-1:0] y,
    output logic              sclk,
    output logic              sync_n,
    output logic              sdata,
    output logic              busy,
    output logic              sat,
    output logic              drop
);
    localparam int FRAME_W = DAC_W + 4;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic signed [DATA_W:0] RND = (DATA_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [DATA_W:0] HI  = (DATA_W+1)'((1 << (DAC_W - 1)) - 1);
    localparam logic signed [DATA_W:0] LO  = ~HI;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_W-1:0]      sh;
    logic [DAC_W-1:0]        pend_code;
    logic [DAC_W-1:0]        conv_code;
    logic [DAC_W-1:0]        start_code;
    logic signed [DATA_W:0]  r;
    logic                    half;
    logic                    gap_cnt;
    logic                    pend;
    logic                    conv_sat;
    logic                    start;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        r          = ($signed({y[DATA_W-1], y}) + RND) >>> SHIFT;
        conv_sat   = (r > HI) || (r < LO);
        conv_code  = (r > HI) ? '1 : (r < LO) ? '0 : {~r[DAC_W-1], r[DAC_W-2:0]};
        start      = (state == S_IDLE && rx_2) || (state == S_GAP && gap_cnt && (rx_2 || pend));
        start_code = rx_2 ? conv_code : pend_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            pend_code <= '0;
            half      <= 1'b0;
            gap_cnt   <= 1'b0;
            pend      <= 1'b0;
            sclk      <= 1'b1;
            sync_n    <= 1'b1;
            sdata     <= 1'b0;
            busy      <= 1'b0;
            sat       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            sat  <= rx_2 && conv_sat;
            drop <= rx_2 && pend;
            if (rx_2 && state != S_IDLE && !start) begin
                pend      <= 1'b1;
                pend_code <= conv_code;
            end
            if (start) begin
                state   <= S_SHIFT;
                sh      <= {4'b0000, start_code};
                sdata   <= 1'b0;
                bit_cnt <= BIT_W'(FRAME_W - 1);
                div_cnt <= '0;
                half    <= 1'b0;
                pend    <= 1'b0;
                sclk    <= 1'b1;
                sync_n  <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                            div_cnt <= '0;
                            half    <= ~half;
                            sclk    <= half;
                            if (half && bit_cnt == '0) begin
                                state   <= S_GAP;
                                sync_n  <= 1'b1;
                                gap_cnt <= 1'b0;
                            end else if (half) begin
                                bit_cnt <= bit_cnt - 1'b1;
                                sh      <= sh << 1;
                                sdata   <= sh[FRAME_W-2];
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= 1'b1;
                        if (gap_cnt) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed frame, rounding, saturation, queueing and reset checks
// for dac_spi_tx at default parameters.
module tb_dac_spi_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_2;
    logic [24:0] y;
    logic        sclk, sync_n, sdata, busy, sat, drop;

    dac_spi_tx dut (
        .clk(clk), .rst(rst), .rx_2(rx_2), .y(y),
        .sclk(sclk), .sync_n(sync_n), .sdata(sdata),
        .busy(busy), .sat(sat), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int low_cnt, busy_cnt, sat_cnt, drop_cnt, nbits;
    logic prev_sclk = 1'b1;
    logic prev_sync = 1'b1;
    logic [15:0] word;
    logic [15:0] frames[$];
    int fall_q[$];
    int drop_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fr(input int i);
        return (frames.size() > i) ? {16'h0, frames[i]} : 32'hDEAD_BEEF;
    endfunction

    // Samples the DUT once per negedge and decodes frames on sclk falling transitions.
    task automatic tick();
        @(negedge clk);
        cyc++;
        low_cnt  += int'(!sync_n);
        busy_cnt += int'(busy);
        sat_cnt  += int'(sat);
        drop_cnt += int'(drop);
        if (drop) drop_q.push_back(cyc);
        if (prev_sync && !sync_n) fall_q.push_back(cyc);
        if (sync_n) nbits = 0;
        else if (prev_sclk && !sclk) begin
            word = {word[14:0], sdata};
            nbits++;
            if (nbits == 16) begin
                frames.push_back(word);
                nbits = 0;
            end
        end
        prev_sclk = sclk;
        prev_sync = sync_n;
    endtask

    task automatic clear();
        low_cnt = 0; busy_cnt = 0; sat_cnt = 0; drop_cnt = 0; nbits = 0;
        frames.delete(); fall_q.delete(); drop_q.delete();
    endtask

    task automatic pulse(input logic [24:0] v);
        rx_2 = 1'b1;
        y    = v;
        tick();
        rx_2 = 1'b0;
    endtask

    task automatic frame_test(input string tag, input logic [24:0] v, input logic [15:0] exp, input int exp_sat);
        clear();
        pulse(v);
        check({tag, "_start"}, {sclk, sync_n, busy, sdata}, 4'b1010);
        repeat (50) tick();
        check({tag, "_nframes"}, frames.size(), 1);
        check({tag, "_frame"}, fr(0), {16'h0, exp});
        check({tag, "_sync_low"}, low_cnt, 32);
        check({tag, "_busy"}, busy_cnt, 34);
        check({tag, "_sat"}, sat_cnt, exp_sat);
    endtask

    int c0;

    initial begin
        rst = 1'b0; rx_2 = 1'b0; y = '0;
        clear();
        repeat (2) tick();
        check("reset_outs", {sclk, sync_n, sdata, busy, sat, drop}, 6'b110000);
        rst = 1'b1;
        repeat (3) tick();

        frame_test("zero",     25'd0,               16'h0800, 0);
        frame_test("rnd_p1536", 25'd1536,           16'h0802, 0);
        frame_test("rnd_m1536", 25'h1FFFA00,        16'h07FF, 0);
        frame_test("rnd_5120", 25'd5120,            16'h0805, 0);
        frame_test("rnd_511",  25'd511,             16'h0800, 0);
        frame_test("sat_max",  25'd16777215,        16'h0FFF, 1);
        frame_test("sat_min",  25'h1000000,         16'h0000, 1);
        frame_test("nosat_max", 25'd2096639,        16'h0FFF, 0);

        // Two samples: second waits in pending and starts on the gap exit edge.
        clear();
        c0 = cyc;
        pulse(25'd1536);
        repeat (9) tick();
        pulse(25'd5120);
        repeat (80) tick();
        check("b2b_nfalls", fall_q.size(), 2);
        check("b2b_spacing", (fall_q.size() == 2) ? fall_q[1] - fall_q[0] : -1, 34);
        check("b2b_drop", drop_cnt, 0);
        check("b2b_f0", fr(0), 32'h0802);
        check("b2b_f1", fr(1), 32'h0805);

        // Three samples: the one at 10 is overwritten by the one at 20.
        clear();
        c0 = cyc;
        pulse(25'd1536);
        repeat (9) tick();
        pulse(25'h1FFFA00);
        repeat (9) tick();
        pulse(25'd511);
        repeat (80) tick();
        check("ovw_drop_cnt", drop_cnt, 1);
        check("ovw_drop_at", (drop_q.size() > 0) ? drop_q[0] - c0 : -1, 21);
        check("ovw_nframes", frames.size(), 2);
        check("ovw_f0", fr(0), 32'h0802);
        check("ovw_f1", fr(1), 32'h0800);

        // New sample on the gap exit edge while one is pending.
        clear();
        c0 = cyc;
        pulse(25'd0);
        repeat (9) tick();
        pulse(25'd16777215);
        repeat (23) tick();
        pulse(25'h1000000);
        repeat (80) tick();
        check("sim_drop", drop_cnt, 1);
        check("sim_drop_at", (drop_q.size() > 0) ? drop_q[0] - c0 : -1, 35);
        check("sim_nframes", frames.size(), 2);
        check("sim_f0", fr(0), 32'h0800);
        check("sim_f1", fr(1), 32'h0000);
        check("sim_fall2", (fall_q.size() > 1) ? fall_q[1] - c0 : -1, 35);
        check("sim_sat", sat_cnt, 2);

        // Asynchronous reset during bit 7 with a sample pending.
        clear();
        pulse(25'd5120);
        repeat (9) tick();
        pulse(25'd1536);
        repeat (6) tick();
        check("rst_pre", {sclk, sync_n, busy}, 3'b101);
        #2 rst = 1'b0;
        #1 check("rst_async", {sclk, sync_n, sdata, busy, sat, drop}, 6'b110000);
        repeat (3) tick();
        rst = 1'b1;
        clear();
        repeat (80) tick();
        check("rst_nframes", frames.size(), 0);
        check("rst_nfalls", fall_q.size(), 0);
        check("rst_busy", busy_cnt, 0);
        frame_test("post_rst", 25'd5120, 16'h0805, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
